// File: rtl/acc_cpu_param.sv
// Parametrised multi-cycle accumulator CPU with internal data memory, Z/C flags
// and a valid/ready instruction port.
module acc_cpu_param #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        opcode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] operand,
  input  logic              write_ena,
  output logic [DATA_W-1:0] acc_out,
  output logic              result_valid,
  output logic              flag_z,
  output logic              flag_c,
  output logic              illegal_op
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_LOAD  = 4'h3;
  localparam logic [3:0] OP_ADDM  = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_XOR   = 4'h7;
  localparam logic [3:0] OP_NOT   = 4'h8;
  localparam logic [3:0] OP_SHL   = 4'h9;
  localparam logic [3:0] OP_SHR   = 4'hA;
  localparam logic [3:0] OP_LDI   = 4'hB;
  localparam logic [3:0] OP_NOP   = 4'hC;

  typedef enum logic [1:0] {S_IDLE, S_MEM, S_EXEC, S_DONE} state_t;

  state_t              state, state_nxt;
  logic                accept;
  logic [3:0]          op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   operand_q;
  logic                we_q;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   mem_rd_q;

  logic [DATA_W-1:0]   add_src;
  logic [DATA_W:0]     sum_ext;
  logic [DATA_W:0]     diff_ext;
  logic [DATA_W-1:0]   acc_nxt;
  logic                c_nxt;
  logic                acc_wr;
  logic                store_en;
  logic                illegal;

  assign accept = instr_valid && instr_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; memory-operand ops take the extra read cycle
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = (opcode == OP_LOAD || opcode == OP_ADDM) ? S_MEM : S_EXEC;
      S_MEM:  state_nxt = S_EXEC;
      S_EXEC: state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Instruction capture at the accept edge only
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= OP_NOP;
      addr_q    <= '0;
      operand_q <= '0;
      we_q      <= 1'b0;
    end else if (state == S_IDLE && accept) begin
      op_q      <= opcode;
      addr_q    <= addr;
      operand_q <= operand;
      we_q      <= write_ena;
    end
  end

  // Execute-stage datapath
  always_comb begin
    acc_nxt  = acc_out;
    c_nxt    = flag_c;
    acc_wr   = 1'b0;
    store_en = 1'b0;
    illegal  = 1'b0;
    add_src  = (op_q == OP_ADDM) ? mem_rd_q : operand_q;
    sum_ext  = {1'b0, acc_out} + {1'b0, add_src};
    diff_ext = {1'b0, acc_out} - {1'b0, operand_q};
    case (op_q)
      OP_ADD, OP_ADDM: begin acc_nxt = sum_ext[DATA_W-1:0];  c_nxt = sum_ext[DATA_W];  acc_wr = 1'b1; end
      OP_SUB:   begin acc_nxt = diff_ext[DATA_W-1:0]; c_nxt = diff_ext[DATA_W]; acc_wr = 1'b1; end
      OP_STORE: store_en = we_q;
      OP_LOAD:  begin acc_nxt = mem_rd_q;              c_nxt = 1'b0; acc_wr = 1'b1; end
      OP_AND:   begin acc_nxt = acc_out & operand_q;   c_nxt = 1'b0; acc_wr = 1'b1; end
      OP_OR:    begin acc_nxt = acc_out | operand_q;   c_nxt = 1'b0; acc_wr = 1'b1; end
      OP_XOR:   begin acc_nxt = acc_out ^ operand_q;   c_nxt = 1'b0; acc_wr = 1'b1; end
      OP_NOT:   begin acc_nxt = ~acc_out;              c_nxt = 1'b0; acc_wr = 1'b1; end
      OP_SHL:   begin acc_nxt = {acc_out[DATA_W-2:0], 1'b0}; c_nxt = acc_out[DATA_W-1]; acc_wr = 1'b1; end
      OP_SHR:   begin acc_nxt = {1'b0, acc_out[DATA_W-1:1]}; c_nxt = acc_out[0];        acc_wr = 1'b1; end
      OP_LDI:   begin acc_nxt = operand_q;             c_nxt = 1'b0; acc_wr = 1'b1; end
      OP_NOP:   ;
      default:  illegal = 1'b1;
    endcase
  end

  // Data memory: cleared on reset, written by STORE in EXEC
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state == S_EXEC && store_en) begin
      mem[addr_q] <= acc_out;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                mem_rd_q <= '0;
    else if (state == S_MEM) mem_rd_q <= mem[addr_q];
  end

  // Architectural state and registered handshake/status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_out      <= '0;
      flag_z       <= 1'b0;
      flag_c       <= 1'b0;
      result_valid <= 1'b0;
      illegal_op   <= 1'b0;
      instr_ready  <= 1'b1;
    end else begin
      if (state == S_EXEC && acc_wr) begin
        acc_out <= acc_nxt;
        flag_c  <= c_nxt;
        flag_z  <= (acc_nxt == '0);
      end
      result_valid <= (state == S_EXEC);
      illegal_op   <= (state == S_EXEC) && illegal;
      instr_ready  <= (state_nxt == S_IDLE);
    end
  end

endmodule

// File: tb/tb_acc_cpu_param.sv
// Self-checking bench for acc_cpu_param: directed vector table, randomized
// instructions against an arithmetic reference model, reset and back-to-back cases.
module tb_acc_cpu_param;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              instr_valid = 1'b0;
  logic              instr_ready;
  logic [3:0]        opcode = 4'h0;
  logic [ADDR_W-1:0] addr = '0;
  logic [DATA_W-1:0] operand = '0;
  logic              write_ena = 1'b0;
  logic [DATA_W-1:0] acc_out;
  logic              result_valid;
  logic              flag_z;
  logic              flag_c;
  logic              illegal_op;

  int checks = 0;
  int failures = 0;

  longint m_acc = 0;
  longint m_z = 0;
  longint m_c = 0;
  longint m_mem [DEPTH];

  acc_cpu_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .addr(addr), .operand(operand), .write_ena(write_ena),
    .acc_out(acc_out), .result_valid(result_valid), .flag_z(flag_z),
    .flag_c(flag_c), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]        op;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] opd;
    logic              we;
    logic [DATA_W-1:0] e_acc;
    logic              e_z;
    logic              e_c;
    logic              e_ill;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: instruction semantics in plain integer arithmetic
  task automatic model_step(input int op, input int a, input longint opd, input int we,
                            output bit ill);
    longint mask = (longint'(1) << DATA_W) - 1;
    longint n = m_acc;
    bit wr = 1'b1;
    ill = 1'b0;
    case (op)
      0:  begin n = m_acc + opd;       m_c = (n > mask) ? 1 : 0; end
      1:  begin n = m_acc - opd;       m_c = (opd > m_acc) ? 1 : 0; end
      2:  begin wr = 1'b0; if (we != 0) m_mem[a] = m_acc; end
      3:  begin n = m_mem[a];          m_c = 0; end
      4:  begin n = m_acc + m_mem[a];  m_c = (n > mask) ? 1 : 0; end
      5:  begin n = m_acc & opd;       m_c = 0; end
      6:  begin n = m_acc | opd;       m_c = 0; end
      7:  begin n = m_acc ^ opd;       m_c = 0; end
      8:  begin n = mask - m_acc;      m_c = 0; end
      9:  begin n = m_acc * 2;         m_c = m_acc / (longint'(1) << (DATA_W - 1)); end
      10: begin n = m_acc / 2;         m_c = m_acc % 2; end
      11: begin n = opd;               m_c = 0; end
      12: wr = 1'b0;
      default: begin wr = 1'b0; ill = 1'b1; end
    endcase
    if (wr) begin
      m_acc = n & mask;
      m_z = (m_acc == 0) ? 1 : 0;
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_z = 0; m_c = 0;
    for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = 0;
  endtask

  // Issue one instruction (call at a negedge); returns at the result_valid negedge
  task automatic run_instr(input logic [3:0] op, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] opd, input logic we,
                           input logic [DATA_W-1:0] e_acc, input logic e_z,
                           input logic e_c, input logic e_ill, input string tag);
    int n = 0;
    int lat = 0;
    bit got = 1'b0;
    int exp_lat = (op == 4'h3 || op == 4'h4) ? 3 : 2;
    while (!instr_ready && n < 10) begin @(negedge clk); n++; end
    if (!instr_ready) check({tag, "_ready_wait"}, 64'(instr_ready), 64'd1);
    opcode = op; addr = a; operand = opd; write_ena = we; instr_valid = 1'b1;
    @(posedge clk);
    while (!got && lat < 8) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        instr_valid = 1'b0;
        opcode = 4'($urandom); addr = ADDR_W'($urandom);
        operand = DATA_W'($urandom); write_ena = 1'($urandom);
      end
      if (result_valid) got = 1'b1;
    end
    check({tag, "_latency"}, 64'(got ? lat : 99), 64'(exp_lat));
    check({tag, "_acc"}, 64'(acc_out), 64'(e_acc));
    check({tag, "_z"}, 64'(flag_z), 64'(e_z));
    check({tag, "_c"}, 64'(flag_c), 64'(e_c));
    check({tag, "_ill"}, 64'(illegal_op), 64'(e_ill));
    check({tag, "_ready_done"}, 64'(instr_ready), 64'd0);
  endtask

  task automatic run_model(input logic [3:0] op, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] opd, input logic we, input string tag);
    bit ill;
    model_step(int'(op), int'(a), longint'(opd), int'(we), ill);
    run_instr(op, a, opd, we, DATA_W'(m_acc), 1'(m_z), 1'(m_c), ill, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepts;
    int nres;
    logic [DATA_W-1:0] res [3];
    bit ill;

    vecs[0]  = '{4'hB, 4'd0, 8'hF0, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{4'h0, 4'd0, 8'h20, 1'b0, 8'h10, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{4'hB, 4'd0, 8'h05, 1'b0, 8'h05, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{4'h1, 4'd0, 8'h05, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{4'h1, 4'd0, 8'h01, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{4'hB, 4'd0, 8'h3C, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{4'h2, 4'd7, 8'h00, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{4'hB, 4'd0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{4'h3, 4'd7, 8'h00, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{4'h2, 4'd8, 8'h00, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{4'h3, 4'd8, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{4'hB, 4'd0, 8'h81, 1'b0, 8'h81, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{4'h9, 4'd0, 8'h00, 1'b0, 8'h02, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{4'hA, 4'd0, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{4'h8, 4'd0, 8'h00, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{4'hE, 4'd0, 8'h00, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b1};
    vecs[16] = '{4'h4, 4'd7, 8'h00, 1'b0, 8'h3A, 1'b0, 1'b1, 1'b0};

    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_acc", 64'(acc_out), 64'd0);
    check("reset_flags", 64'({flag_z, flag_c}), 64'd0);
    check("reset_rv", 64'({result_valid, illegal_op}), 64'd0);
    @(negedge clk);
    check("reset_ready", 64'(instr_ready), 64'd1);

    // Directed vector table; model is stepped alongside for later phases
    for (int i = 0; i < 17; i++) begin
      model_step(int'(vecs[i].op), int'(vecs[i].a), longint'(vecs[i].opd), int'(vecs[i].we), ill);
      run_instr(vecs[i].op, vecs[i].a, vecs[i].opd, vecs[i].we,
                vecs[i].e_acc, vecs[i].e_z, vecs[i].e_c, vecs[i].e_ill, $sformatf("vec%0d", i));
    end

    // Randomized instruction stream against the model
    for (int i = 0; i < 80; i++) begin
      run_model(4'($urandom_range(0, 15)), ADDR_W'($urandom), DATA_W'($urandom),
                1'($urandom), $sformatf("rnd%0d", i));
    end

    // Reset during the MEM cycle of a LOAD
    run_model(4'hB, '0, 8'h5A, 1'b0, "pre_ldi");
    run_model(4'h2, ADDR_W'(3), 8'h00, 1'b1, "pre_st3");
    run_model(4'h2, ADDR_W'(12), 8'h00, 1'b1, "pre_st12");
    @(negedge clk);
    opcode = 4'h3; addr = ADDR_W'(3); instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rst_mem_rv%0d", i), 64'(result_valid), 64'd0);
    end
    rst = 1'b0;
    model_reset();
    check("rst_mem_acc", 64'(acc_out), 64'd0);
    check("rst_mem_flags", 64'({flag_z, flag_c}), 64'd0);
    @(negedge clk);
    check("rst_mem_ready", 64'(instr_ready), 64'd1);
    check("rst_mem_rv_after", 64'(result_valid), 64'd0);
    for (int i = 0; i < int'(DEPTH); i++) begin
      run_model(4'h3, ADDR_W'(i), 8'h00, 1'b0, $sformatf("clr%0d", i));
    end

    // Back-to-back ADD 1 with instr_valid held high
    run_model(4'hB, '0, 8'h00, 1'b0, "b2b_ldi0");
    @(negedge clk);
    opcode = 4'h0; operand = 8'h01; instr_valid = 1'b1;
    accepts = 0; nres = 0;
    for (int i = 0; i < 9; i++) begin
      if (instr_ready) accepts++;
      check($sformatf("b2b_ready%0d", i), 64'(instr_ready), 64'((i % 3) == 0));
      if (result_valid && nres < 3) begin res[nres] = acc_out; nres++; end
      @(negedge clk);
    end
    instr_valid = 1'b0;
    check("b2b_accepts", 64'(accepts), 64'd3);
    check("b2b_results", 64'(nres), 64'd3);
    for (int i = 0; i < 3; i++) begin
      model_step(0, 0, 1, 0, ill);
      if (i < nres) check($sformatf("b2b_acc%0d", i), 64'(res[i]), 64'(m_acc));
    end
    run_model(4'hC, '0, 8'h00, 1'b0, "b2b_nop");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
